// File: rtl/dm_subword_pkg.sv
// Shared encodings for the sub-word data memory: access sizes, FSM states,
// and the write-log record driven on every committed store.
package dm_subword_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } wlog_t;

    // Reserved size 2'b11 falls into the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic r;
        case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = lo[0];
            default: r = (lo != 2'b00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational lane logic: store byte-enables and merge, load lane select
// with sign/zero extension, and the alignment check.
module dm_lane_unit
    import dm_subword_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        sign_ext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o,
    output logic        misalign_o
);

    logic [3:0]  be;
    logic [31:0] wrep;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        misalign_o = is_misaligned(size_i, addr_lo_i);
        be         = 4'b1111;
        wrep       = wdata_i;
        // Store data is replicated across lanes so the enables alone pick the target.
        case (size_i)
            SZ_BYTE: begin
                be   = 4'b0001 << addr_lo_i;
                wrep = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                be   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata_i[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wrep = wdata_i;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            merged_o[8*i +: 8] = be[i] ? wrep[8*i +: 8] : rword_i[8*i +: 8];
        end
    end

    always_comb begin
        rbyte = rword_i[8*addr_lo_i +: 8];
        rhalf = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        case (size_i)
            SZ_BYTE: load_o = {{24{sign_ext_i & rbyte[7]}}, rbyte};
            SZ_HALF: load_o = {{16{sign_ext_i & rhalf[15]}}, rhalf};
            default: load_o = rword_i;
        endcase
    end

endmodule

// File: rtl/dm_subword.sv
// Data memory with byte/halfword/word access, valid/ready request handshake
// and configurable wait states; the FSM, array and response registers live here.
module dm_subword
    import dm_subword_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        misalign,
    output state_t      dbg_state,
    output wlog_t       dbg_wlog
);

    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; the requester holds its request until then.
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q, sext_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, pc_q;
    logic        resp_valid_q, misalign_q;
    logic [31:0] rdata_q;
    wlog_t       wlog_q;
    logic [31:0] mem_q [DEPTH];

    logic              cur_we, cur_sext;
    logic [1:0]        cur_size;
    logic [31:0]       cur_addr, cur_wdata, cur_pc;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rword, merged, load_val;
    logic              mis, enter_resp;

    // With no wait states the response is formed on the acceptance edge,
    // before the latched copy exists, so the live inputs are used in IDLE.
    always_comb begin
        cur_we    = (state_q == S_IDLE) ? we       : we_q;
        cur_sext  = (state_q == S_IDLE) ? sign_ext : sext_q;
        cur_size  = (state_q == S_IDLE) ? size     : size_q;
        cur_addr  = (state_q == S_IDLE) ? addr     : addr_q;
        cur_wdata = (state_q == S_IDLE) ? wdata    : wdata_q;
        cur_pc    = (state_q == S_IDLE) ? pc       : pc_q;
        word_idx  = cur_addr[ADDR_W+1:2];
        rword     = mem_q[word_idx];
        enter_resp = ((state_q == S_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == WAIT_LAST));
    end

    dm_lane_unit u_lane (
        .size_i     (cur_size),
        .addr_lo_i  (cur_addr[1:0]),
        .sign_ext_i (cur_sext),
        .wdata_i    (cur_wdata),
        .rword_i    (rword),
        .merged_o   (merged),
        .load_o     (load_val),
        .misalign_o (mis)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            sext_q       <= 1'b0;
            size_q       <= SZ_BYTE;
            addr_q       <= '0;
            wdata_q      <= '0;
            pc_q         <= '0;
            resp_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            rdata_q      <= '0;
            wlog_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            resp_valid_q <= 1'b0;
            wlog_q.valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= we;
                        sext_q  <= sign_ext;
                        size_q  <= size;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        pc_q    <= pc;
                        cnt_q   <= (WAIT_CYCLES == 0) ? 4'd0 : 4'd1;
                        state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            // Commit and load capture share the edge that enters RESP.
            if (enter_resp) begin
                resp_valid_q <= 1'b1;
                misalign_q   <= mis;
                rdata_q      <= (cur_we || mis) ? 32'd0 : load_val;
                if (cur_we && !mis) begin
                    mem_q[word_idx] <= merged;
                    wlog_q          <= '{valid: 1'b1, pc: cur_pc,
                                         addr: {cur_addr[31:2], 2'b00}, data: merged};
                end
            end
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign misalign   = misalign_q;
    assign dbg_state  = state_q;
    assign dbg_wlog   = wlog_q;

endmodule

// File: tb/tb_dm_subword.sv
// Bench for dm_subword: instance 0 has no wait states, instance 1 has three.
// Byte-level reference memory, directed table, hand sequences, random traffic.
module tb_dm_subword;
  import dm_subword_pkg::*;

  localparam int WAITS[2] = '{0, 3};

  logic clk;
  logic rst;
  logic        rv   [2];
  logic        wr   [2];
  logic [1:0]  sz   [2];
  logic        sx   [2];
  logic [31:0] ad   [2];
  logic [31:0] wd   [2];
  logic [31:0] pcv  [2];
  logic        rdy  [2];
  logic        rsp  [2];
  logic [31:0] rdat [2];
  logic        mis  [2];
  state_t      dst  [2];
  wlog_t       wlog [2];

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];
  bit [31:0] model_mem [2][4096];

  dm_subword #(.ADDR_W(12), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .we(wr[0]),
    .size(sz[0]), .sign_ext(sx[0]), .addr(ad[0]), .wdata(wd[0]), .pc(pcv[0]),
    .resp_valid(rsp[0]), .rdata(rdat[0]), .misalign(mis[0]),
    .dbg_state(dst[0]), .dbg_wlog(wlog[0])
  );

  dm_subword #(.ADDR_W(12), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .we(wr[1]),
    .size(sz[1]), .sign_ext(sx[1]), .addr(ad[1]), .wdata(wd[1]), .pc(pcv[1]),
    .resp_valid(rsp[1]), .rdata(rdat[1]), .misalign(mis[1]),
    .dbg_state(dst[1]), .dbg_wlog(wlog[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4096; i++)
        model_mem[d][i] = '0;
  endtask

  // Reference: byte-wise little-endian memory with arithmetic extension.
  task automatic model_apply(input int d, input logic w, input logic [1:0] s, input logic x,
                             input logic [31:0] a, input logic [31:0] dat,
                             output logic m, output logic [31:0] rd, output logic [31:0] word);
    int nb, off, idx;
    longint v;
    nb  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    off = int'(a % 4);
    idx = int'((a / 4) % 4096);
    m   = (a % 32'(nb)) != 0;
    rd  = '0;
    if (!m && w)
      for (int b = 0; b < nb; b++)
        model_mem[d][idx][8*(off+b) +: 8] = dat[8*b +: 8];
    if (!m && !w) begin
      v = 0;
      for (int b = 0; b < nb; b++)
        v += longint'(model_mem[d][idx][8*(off+b) +: 8]) << (8*b);
      if (x && v >= (longint'(1) << (8*nb - 1)))
        v -= longint'(1) << (8*nb);
      rd = v[31:0];
    end
    word = model_mem[d][idx];
  endtask

  // driver: one request, waits for the response, checks it against exp_q
  task automatic do_req(input int d, input logic w, input logic [1:0] s, input logic x,
                        input logic [31:0] a, input logic [31:0] dat, input logic [31:0] p,
                        input logic [31:0] exp_rd, input logic exp_mis, input logic [31:0] exp_word);
    int waited, lat;
    logic [32:0] e;
    exp_q.push_back({exp_mis, exp_rd});
    @(negedge clk);
    wr[d] = w; sz[d] = s; sx[d] = x; ad[d] = a; wd[d] = dat; pcv[d] = p; rv[d] = 1'b1;
    waited = 0;
    while (!rdy[d] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!rdy[d]) begin
      n_vec++;
      n_err++;
      $display("FAIL accept dut%0d: req_ready low for %0d cycles, required high", d, waited);
      rv[d] = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(posedge clk);
    #1;
    rv[d] = 1'b0;
    lat = 0;
    while (!rsp[d] && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("latency dut%0d addr %h", d, a), 32'(lat), 32'(WAITS[d]));
    e = exp_q.pop_front();
    check($sformatf("rdata dut%0d addr %h", d, a), rdat[d], e[31:0]);
    check($sformatf("misalign dut%0d addr %h", d, a), 32'(mis[d]), 32'(e[32]));
    check($sformatf("log_valid dut%0d addr %h", d, a), 32'(wlog[d].valid), 32'(w && !exp_mis));
    if (w && !exp_mis) begin
      $display("@%h: *%h <= %h", wlog[d].pc, wlog[d].addr, wlog[d].data);
      check($sformatf("log_data dut%0d addr %h", d, a), wlog[d].data, exp_word);
      check($sformatf("log_addr dut%0d addr %h", d, a), wlog[d].addr, {a[31:2], 2'b00});
    end
    @(posedge clk);
    #1;
    check($sformatf("resp_pulse dut%0d", d), 32'(rsp[d]), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  function automatic vec_t mkv(input logic w, input logic [1:0] s, input logic x,
                               input logic [31:0] a, input logic [31:0] dat,
                               input logic [31:0] erd, input logic em);
    vec_t v;
    v.we = w; v.size = s; v.sext = x; v.addr = a; v.wdata = dat; v.exp_rd = erd; v.exp_mis = em;
    return v;
  endfunction

  initial begin
    vec_t tab[18];
    logic m;
    logic [31:0] rd, word;
    int acc[$];
    int rsps[$];
    int ready_low, pulses;

    tab[0]  = mkv(0, SZ_WORD, 0, 32'h0000_0000, 32'h0,          32'h0000_0000, 0);
    tab[1]  = mkv(1, SZ_WORD, 0, 32'h0000_0010, 32'h1234_5678,  32'h0000_0000, 0);
    tab[2]  = mkv(1, SZ_BYTE, 0, 32'h0000_0011, 32'h0000_00AB,  32'h0000_0000, 0);
    tab[3]  = mkv(0, SZ_WORD, 0, 32'h0000_0010, 32'h0,          32'h1234_AB78, 0);
    tab[4]  = mkv(0, SZ_BYTE, 1, 32'h0000_0011, 32'h0,          32'hFFFF_FFAB, 0);
    tab[5]  = mkv(0, SZ_BYTE, 0, 32'h0000_0011, 32'h0,          32'h0000_00AB, 0);
    tab[6]  = mkv(1, SZ_HALF, 0, 32'h0000_0022, 32'h0000_8001,  32'h0000_0000, 0);
    tab[7]  = mkv(0, SZ_HALF, 1, 32'h0000_0022, 32'h0,          32'hFFFF_8001, 0);
    tab[8]  = mkv(0, SZ_HALF, 0, 32'h0000_0022, 32'h0,          32'h0000_8001, 0);
    tab[9]  = mkv(0, SZ_WORD, 0, 32'h0000_0020, 32'h0,          32'h8001_0000, 0);
    tab[10] = mkv(1, SZ_HALF, 0, 32'h0000_0013, 32'h0000_BEEF,  32'h0000_0000, 1);
    tab[11] = mkv(0, SZ_WORD, 0, 32'h0000_0012, 32'h0,          32'h0000_0000, 1);
    tab[12] = mkv(0, SZ_WORD, 0, 32'h0000_0010, 32'h0,          32'h1234_AB78, 0);
    tab[13] = mkv(1, SZ_WORD, 0, 32'h0000_4000, 32'hCAFE_F00D,  32'h0000_0000, 0);
    tab[14] = mkv(0, SZ_WORD, 0, 32'h0000_0000, 32'h0,          32'hCAFE_F00D, 0);
    tab[15] = mkv(0, 2'b11,   0, 32'h0000_0010, 32'h0,          32'h1234_AB78, 0);
    tab[16] = mkv(0, 2'b11,   0, 32'h0000_0012, 32'h0,          32'h0000_0000, 1);
    tab[17] = mkv(0, SZ_BYTE, 1, 32'h0000_0023, 32'h0,          32'hFFFF_FF80, 0);

    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 0; wr[d] = 0; sz[d] = '0; sx[d] = 0; ad[d] = '0; wd[d] = '0; pcv[d] = '0;
    end
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset req_ready dut%0d", d), 32'(rdy[d]), 32'd1);
      check($sformatf("reset resp_valid dut%0d", d), 32'(rsp[d]), 32'd0);
      check($sformatf("reset rdata dut%0d", d), rdat[d], 32'd0);
      check($sformatf("reset misalign dut%0d", d), 32'(mis[d]), 32'd0);
      check($sformatf("reset state dut%0d", d), 32'(dst[d]), 32'(S_IDLE));
    end

    // directed table on the zero-wait instance
    for (int i = 0; i < 18; i++) begin
      model_apply(0, tab[i].we, tab[i].size, tab[i].sext, tab[i].addr, tab[i].wdata, m, rd, word);
      do_req(0, tab[i].we, tab[i].size, tab[i].sext, tab[i].addr, tab[i].wdata,
             32'h0000_1000 + 32'(4*i), tab[i].exp_rd, tab[i].exp_mis, word);
    end

    // request held high on the 3-wait instance
    model_apply(1, 1, SZ_WORD, 0, 32'h44, 32'h5A5A_0001, m, rd, word);
    @(negedge clk);
    wr[1] = 1; sz[1] = SZ_WORD; sx[1] = 0; ad[1] = 32'h44; wd[1] = 32'h5A5A_0001; pcv[1] = 32'h2000;
    rv[1] = 1'b1;
    ready_low = 0;
    for (int k = 0; k < 12; k++) begin
      if (rdy[1]) acc.push_back(k);
      else if (k >= 1 && k <= 4) ready_low++;
      @(posedge clk);
      #1;
      if (rsp[1]) rsps.push_back(k);
      @(negedge clk);
    end
    rv[1] = 1'b0;
    repeat (6) @(posedge clk);
    check("held accept_count", 32'(acc.size()), 32'd3);
    check("held second_accept_edge", (acc.size() > 1) ? 32'(acc[1]) : 32'hFFFF_FFFF, 32'd5);
    check("held first_resp_edge", (rsps.size() > 0) ? 32'(rsps[0]) : 32'hFFFF_FFFF, 32'd3);
    check("held ready_low_cycles", 32'(ready_low), 32'd4);
    do_req(1, 0, SZ_WORD, 0, 32'h44, 32'h0, 32'h2004, 32'h5A5A_0001, 0, 32'h0);

    // reset during WAIT of a store
    model_apply(1, 1, SZ_WORD, 0, 32'h80, 32'h1111_2222, m, rd, word);
    do_req(1, 1, SZ_WORD, 0, 32'h80, 32'h1111_2222, 32'h3000, 32'h0, 0, word);
    @(negedge clk);
    wr[1] = 1; sz[1] = SZ_WORD; sx[1] = 0; ad[1] = 32'h40; wd[1] = 32'hDEAD_BEEF; pcv[1] = 32'h3004;
    rv[1] = 1'b1;
    @(posedge clk);
    #1;
    rv[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset rdata", rdat[1], 32'd0);
    check("midreset resp_valid", 32'(rsp[1]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (rsp[1]) pulses++;
    end
    check("midreset no_response", 32'(pulses), 32'd0);
    check("midreset state", 32'(dst[1]), 32'(S_IDLE));
    do_req(1, 0, SZ_WORD, 0, 32'h40, 32'h0, 32'h3008, 32'h0, 0, 32'h0);
    do_req(1, 0, SZ_WORD, 0, 32'h80, 32'h0, 32'h300C, 32'h0, 0, 32'h0);
    do_req(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'h3010, 32'h0, 0, 32'h0);

    // random traffic against the reference model, both instances
    for (int i = 0; i < 300; i++) begin
      int d;
      logic w, x;
      logic [1:0] s;
      logic [31:0] a, dat, p;
      d   = i % 2;
      w   = 1'($urandom_range(0, 1));
      x   = 1'($urandom_range(0, 1));
      s   = 2'($urandom_range(0, 3));
      a   = ($urandom() & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
      dat = $urandom();
      p   = $urandom() & 32'hFFFF_FFFC;
      model_apply(d, w, s, x, a, dat, m, rd, word);
      do_req(d, w, s, x, a, dat, p, rd, m, word);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dm_subword.md
Name: dm_subword

Overview:
Parametrised data memory for the single-cycle/multi-cycle CPU datapath; successor to the fixed 4096-word, word-only DM.
- Adds byte/halfword/word stores and loads with sign or zero extension, and misalignment detection.
- Adds a valid/ready request handshake with configurable wait states.
- Sits between the EX/MEM stage and the load-extend path and keeps the simulation write log.

Parameters:
ADDR_W, 12, word-address bits; depth = 2**ADDR_W words of 32 bits.
WAIT_CYCLES, 0, extra stall cycles between request acceptance and response (0..15).

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request (high only in IDLE).
we  in  1  1 = store, 0 = load; sampled on acceptance.
size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
addr  in  32  byte address; bits [ADDR_W+1:0] used, upper bits ignored (wrap).
wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
pc  in  32  PC of the issuing instruction, for the write log only.
resp_valid  out  1  one-cycle response pulse.
rdata  out  32  extended load data; 0 for stores and misaligned accesses.
misalign  out  1  valid with resp_valid: access was misaligned and was suppressed.

Behaviour:
- Reset (rst low, async): FSM goes to IDLE, wait counter = 0, resp_valid = 0, rdata = 0, misalign = 0, req_ready = 1 once released. Every memory word is cleared to 0. The array is also zero at time 0.
- FSM states IDLE, WAIT, RESP.
  - IDLE: if req_valid, latch we/size/sign_ext/addr/wdata/pc. Go to WAIT if WAIT_CYCLES > 0, else RESP.
  - WAIT: counter counts 1..WAIT_CYCLES, then goes to RESP.
  - RESP: resp_valid = 1 for exactly one cycle, then back to IDLE.
- Latency: a request accepted at edge N gives resp_valid high in cycle N+1+WAIT_CYCLES. Back-to-back throughput is one request per 2+WAIT_CYCLES cycles.
- req_ready is 1 only in IDLE. Requests presented while not in IDLE are ignored; the requester holds them.
- Alignment:
  - halfword needs addr[0] = 0;
  - word/reserved needs addr[1:0] = 0;
  - byte is always aligned.
  - A misaligned store writes nothing. A misaligned load returns rdata = 0. Both set misalign = 1 with resp_valid.
- Lane mapping is little-endian. Byte k = addr[1:0] sits in bits [8k+7:8k]; halfword at addr[1] sits in bits [16*addr[1]+15:16*addr[1]].
- Store commit:
  - Happens on the edge entering RESP.
  - Read-modify-write of the target word, with only the enabled lanes replaced by the low bits of wdata.
  - Simulation prints "@<pc>: *<addr> <= <merged word>" in hex, where addr is the word-aligned byte address.
- Load:
  - The word is read on the edge entering RESP.
  - The lane is selected and extended to 32 bits, then registered into rdata.
  - rdata holds its value until the next response.
- A store followed by a load to the same word sees the new data, because the commit precedes the next acceptance.
- Reset asserted mid-operation aborts the transaction. Any store not yet committed is dropped, no response is issued, and the memory is cleared.
- Address wrap: addr bits above ADDR_W+1 are ignored, so 0x0000_4000 aliases 0x0 when ADDR_W = 12.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - FSM state encodings S_IDLE, S_WAIT, S_RESP.
- One sub-module, dm_lane_unit (combinational), provides:
  - byte-enable generation and write-data merge;
  - load lane select and extension;
  - misalignment check.
- The parent holds the FSM, counter, array and registers.

Test Plan:
- Reset then word load at 0x0 -> resp_valid one cycle after acceptance (WAIT_CYCLES = 0), rdata = 0x0000_0000, misalign = 0.
- Word store 0x1234_5678 to 0x10, then byte store 0xAB to 0x11 -> log shows 0x1234_AB78; lb at 0x11 with sign_ext = 1 -> 0xFFFF_FFAB; lbu -> 0x0000_00AB.
- Half store 0x8001 to 0x22, then lh at 0x22 -> 0xFFFF_8001; lhu -> 0x0000_8001; word load at 0x20 -> 0x8001_0000.
- Halfword store to 0x13 and word load at 0x12 -> misalign = 1, rdata = 0, memory word 0x10 unchanged.
- WAIT_CYCLES = 3, request held high -> req_ready low for 4 cycles, resp_valid in cycle N+4; a second request is accepted only after returning to IDLE.
- rst pulsed low during WAIT of a store to 0x40 -> no resp_valid, rdata = 0; later load at 0x40 returns 0; store to 0x4000 aliases word 0 (ADDR_W = 12).
